pipe_addsub: RTL and testbench
==============================

# pipe_addsub

Parametrised, pipelined carry-ripple adder/subtractor. It is the successor to the team's fixed 32-bit clocked full adder. The datapath is split into WIDTH/SEG ripple segments, one per pipeline stage, so WIDTH can scale without lengthening the critical path. A valid/ready handshake on both sides lets it sit between streaming producers and consumers in the arithmetic datapath. A per-operation mode bit selects add or subtract, and the block reports carry and signed overflow.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, bits resolved per pipeline stage; STAGES = WIDTH/SEG (derived, not a port parameter).
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  a, b, cin, sub are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- a  input  WIDTH  operand A (unsigned/two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  s, cout, ovf hold a result.
- out_ready  input  1  consumer takes result this cycle.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of MSB (subtract: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

## Operation
- Operand prep at accept: b' = sub ? ~b : b; c0 = sub ? ~cin : cin.
  - sub=0 computes a + b + cin.
  - sub=1 computes a - b - cin, i.e. a + ~b + ~cin.
- Stage k (0..STAGES-1) adds segment k of a and b' (bits k*SEG .. k*SEG+SEG-1) with the carry registered from stage k-1 (stage 0 uses c0).
  - Result segments already produced are skewed forward through later stages.
  - Upper operand segments are carried forward until their stage.
- Result semantics:
  - s = low WIDTH bits of the full sum.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Each stage carries a valid bit. Bubbles propagate as invalid slots; there is no compaction.
- Global stall: stall = out_valid & ~out_ready.
  - While stall is 1, every stage register (data and valid) holds.
  - in_ready = ~stall, combinational from out_valid and out_ready.
- Transfer rules:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - When in_valid=0 and in_ready=1, a bubble enters stage 0.
- Results leave strictly in acceptance order, with no loss or duplication.
- STAGES=1 degenerates to a single registered adder with the same handshake.

## Timing
- Latency: a result accepted at edge t appears with out_valid=1 after edge t+STAGES-1, absent stalls. For WIDTH=32, SEG=8 that is 4 cycles from acceptance to the output being consumable.
- Each stall cycle adds one cycle to the latency of every in-flight item.
- Throughput: one operation per cycle when out_ready is held at 1.
- While out_valid=1 and out_ready=0, s, cout and ovf must be held stable, with no glitch between edges.
- Reset (rst_n=0), asynchronous and effective immediately:
  - all stage valid bits = 0; out_valid = 0; s = 0; cout = 0; ovf = 0; internal carries = 0; in_ready = 1.
- Reset mid-operation discards all in-flight operations. No partial result may emerge after reset deassertion.
- First accept is possible at the first rising edge with rst_n=1.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: the output is consumed, the pipe advances, and the new input is accepted in the same edge.
- Wrap-around: the sum wraps modulo 2^WIDTH; the dropped carry appears only on cout.

## Test plan
- Reset: drive 3 operations, then pull rst_n low between edges -> out_valid, s, cout, ovf go to 0 immediately; after release, no stale result ever appears.
- Carry chain across all segments, WIDTH=32, SEG=8, sub=0: a=0xFFFFFFFF, b=0x00000001, cin=0 -> 4 cycles later s=0x00000000, cout=1, ovf=0.
- Signed overflow on add: a=0x7FFFFFFF, b=1, cin=0, sub=0 -> s=0x80000000, cout=0, ovf=1.
- Subtract, three cases (all sub=1, cin=0 unless stated):
  - a=5, b=7 -> s=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1 -> s=0x7FFFFFFF, cout=1, ovf=1.
  - a=10, b=3, cin=1 -> s=6, cout=1.
- Stream with backpressure:
  - Stimulus: a=b=i for i=0..99, in_valid random 70%, out_ready random 50%.
  - Required: outputs exactly 2i in order; s is stable during every stall; no drops or duplicates.
- Parameter corners:
  - WIDTH=8, SEG=8: 0xFF+0x01 -> s=0x00, cout=1, latency 1.
  - WIDTH=12, SEG=4: 0xFFF+0x001 with cin=1 -> s=0x001, cout=1 after 3 cycles.

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined ripple adder/subtractor, one SEG-bit ripple segment per stage.
// Latency: STAGES cycles from accept to consumable (result visible after edge t+STAGES-1).
// Backpressure: global stall when out_valid & ~out_ready; every stage holds, in_ready drops.
module pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [SEG:0]      seg_sum [STAGES];
    logic              ovf_q, ovf_d;
    logic              stall;

    assign stall    = vld_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        // Stage 0 folds the subtract into inverted B and inverted carry-in.
        opa_d[0]   = a;
        opb_d[0]   = sub ? ~b : b;
        vld_d[0]   = in_valid;
        seg_sum[0] = {1'b0, a[SEG-1:0]} + {1'b0, opb_d[0][SEG-1:0]}
                   + {{SEG{1'b0}}, sub ^ cin};
        res_d[0]   = '0;
        res_d[0][SEG-1:0] = seg_sum[0][SEG-1:0];
        cy_d[0]    = seg_sum[0][SEG];
        for (int k = 1; k < STAGES; k++) begin
            opa_d[k]   = opa_q[k-1];
            opb_d[k]   = opb_q[k-1];
            vld_d[k]   = vld_q[k-1];
            seg_sum[k] = {1'b0, opa_q[k-1][k*SEG +: SEG]}
                       + {1'b0, opb_q[k-1][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, cy_q[k-1]};
            res_d[k]   = res_q[k-1];
            res_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
            cy_d[k]    = seg_sum[k][SEG];
        end
        // Carry into the MSB is recovered as a^b^sum at that bit.
        ovf_d = opa_d[STAGES-1][WIDTH-1] ^ opb_d[STAGES-1][WIDTH-1]
              ^ res_d[STAGES-1][WIDTH-1] ^ cy_d[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else if (!stall) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign s         = res_q[STAGES-1];
    assign cout      = cy_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub: 32/8 main instance plus 8/8 and 12/4 corners.
module tb_pipe_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, s;
    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, s8;
    logic        in_valid12, in_ready12, cin12, sub12, out_valid12, out_ready12, cout12, ovf12;
    logic [11:0] a12, b12, s12;

    int passed = 0;
    int total  = 0;

    pipe_addsub #(.WIDTH(32), .SEG(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf));

    pipe_addsub #(.WIDTH(8), .SEG(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8));

    pipe_addsub #(.WIDTH(12), .SEG(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .in_ready(in_ready12),
        .a(a12), .b(b12), .cin(cin12), .sub(sub12), .out_valid(out_valid12),
        .out_ready(out_ready12), .s(s12), .cout(cout12), .ovf(ovf12));

    // Issues one op on the 32-bit instance and returns the result once out_valid rises.
    task automatic op32(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                        input logic isub, output logic [31:0] os, output logic ocout,
                        output logic oovf, output int lat);
        a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        os = s; ocout = cout; oovf = ovf;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0;
        in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        in_valid12 = 0; out_ready12 = 1; a12 = 0; b12 = 0; cin12 = 0; sub12 = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (s !== 32'h0) $display("FAIL reset_s: got %h want 0", s); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if ({out_valid8, out_valid12} !== 2'b00) $display("FAIL reset_corner_valid: got %b want 00", {out_valid8, out_valid12}); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midop;
        int seen;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'hFFFF_FFFF; b = 32'(i + 2); cin = 0; sub = 0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        total++; if ({out_valid, cout, s} !== {2'b11, 32'h1}) $display("FAIL pre_reset_result: got %b%b %h want 11 00000001", out_valid, cout, s); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if ({s, cout, ovf} !== 34'h0) $display("FAIL midreset_outputs: got %h %b %b want 0 0 0", s, cout, ovf); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b want 1", in_ready); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) $display("FAIL stale_after_reset: got %0d results want 0", seen); else passed++;
    endtask

    task automatic test_carry_chain;
        logic [31:0] rs; logic rc, ro; int lat;
        op32(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, rs, rc, ro, lat);
        total++; if (lat !== 3) $display("FAIL chain_latency: got %0d edges want 3", lat); else passed++;
        total++; if (rs !== 32'h0) $display("FAIL chain_s: got %h want 00000000", rs); else passed++;
        total++; if ({rc, ro} !== 2'b10) $display("FAIL chain_cout_ovf: got %b want 10", {rc, ro}); else passed++;
    endtask

    task automatic test_add_ovf;
        logic [31:0] rs; logic rc, ro; int lat;
        op32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, rs, rc, ro, lat);
        total++; if (rs !== 32'h8000_0000) $display("FAIL addovf_s: got %h want 80000000", rs); else passed++;
        total++; if ({rc, ro} !== 2'b01) $display("FAIL addovf_cout_ovf: got %b want 01", {rc, ro}); else passed++;
    endtask

    task automatic test_subtract;
        logic [31:0] rs; logic rc, ro; int lat;
        op32(32'd5, 32'd7, 1'b0, 1'b1, rs, rc, ro, lat);
        total++; if (rs !== 32'hFFFF_FFFE) $display("FAIL sub_5_7_s: got %h want fffffffe", rs); else passed++;
        total++; if ({rc, ro} !== 2'b00) $display("FAIL sub_5_7_cout_ovf: got %b want 00", {rc, ro}); else passed++;
        op32(32'h8000_0000, 32'd1, 1'b0, 1'b1, rs, rc, ro, lat);
        total++; if (rs !== 32'h7FFF_FFFF) $display("FAIL sub_min_s: got %h want 7fffffff", rs); else passed++;
        total++; if ({rc, ro} !== 2'b11) $display("FAIL sub_min_cout_ovf: got %b want 11", {rc, ro}); else passed++;
        op32(32'd10, 32'd3, 1'b1, 1'b1, rs, rc, ro, lat);
        total++; if (rs !== 32'd6) $display("FAIL sub_borrow_s: got %h want 00000006", rs); else passed++;
        total++; if ({rc, ro} !== 2'b10) $display("FAIL sub_borrow_cout_ovf: got %b want 10", {rc, ro}); else passed++;
    endtask

    task automatic test_back_to_back;
        int acc, got;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        acc = 0; got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            in_valid = (acc < 8); a = 32'(acc); b = 32'(acc * 16); cin = 0; sub = 0;
            out_ready = (c >= 6);
            #1;
            if (c == 5) begin
                total++; if (in_ready !== 1'b0) $display("FAIL full_stall_in_ready: got %b want 0", in_ready); else passed++;
            end
            if (c == 6) begin
                total++; if ({in_ready, out_valid} !== 2'b11) $display("FAIL full_simul_xfer: got %b want 11", {in_ready, out_valid}); else passed++;
            end
            if (out_valid && out_ready) begin
                total++; if (s !== 32'(17 * got)) $display("FAIL b2b_item%0d: got %h want %h", got, s, 32'(17 * got)); else passed++;
                got++;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++; if (got !== 8) $display("FAIL b2b_count: got %0d want 8", got); else passed++;
    endtask

    task automatic test_stream;
        int acc, got, stall_err, extra;
        acc = 0; got = 0; stall_err = 0; extra = 0;
        fork
            begin
                for (int c = 0; c < 3000 && acc < 100; c++) begin
                    in_valid = ($urandom_range(0, 9) < 7); a = 32'(acc); b = 32'(acc); cin = 0; sub = 0;
                    #1;
                    if (in_valid && in_ready) acc++;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                logic prev_stall;
                logic [31:0] prev_s;
                prev_stall = 1'b0; prev_s = '0;
                for (int c = 0; c < 3000 && got < 100; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    #1;
                    if (prev_stall && (out_valid !== 1'b1 || s !== prev_s)) stall_err++;
                    if (out_valid && out_ready) begin
                        total++; if (s !== 32'(2 * got)) $display("FAIL stream_item%0d: got %h want %h", got, s, 32'(2 * got)); else passed++;
                        got++;
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_s = s;
                    @(posedge clk); #1;
                end
            end
        join
        total++; if (acc !== 100) $display("FAIL stream_accepted: got %0d want 100", acc); else passed++;
        total++; if (got !== 100) $display("FAIL stream_delivered: got %0d want 100", got); else passed++;
        total++; if (stall_err !== 0) $display("FAIL stream_stall_stable: got %0d violations want 0", stall_err); else passed++;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) extra++;
        end
        total++; if (extra !== 0) $display("FAIL stream_duplicates: got %0d extra want 0", extra); else passed++;
    endtask

    task automatic test_corners;
        int lat;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 0; sub8 = 0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        total++; if (out_valid8 !== 1'b1) $display("FAIL w8_latency: got out_valid %b want 1", out_valid8); else passed++;
        total++; if ({s8, cout8} !== {8'h00, 1'b1}) $display("FAIL w8_result: got %h %b want 00 1", s8, cout8); else passed++;
        @(posedge clk); #1;
        a12 = 12'hFFF; b12 = 12'h001; cin12 = 1; sub12 = 0; in_valid12 = 1'b1;
        @(posedge clk); #1;
        in_valid12 = 1'b0;
        lat = 0;
        while (out_valid12 !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 2) $display("FAIL w12_latency: got %0d edges want 2", lat); else passed++;
        total++; if ({s12, cout12, ovf12} !== {12'h001, 2'b10}) $display("FAIL w12_result: got %h %b %b want 001 1 0", s12, cout12, ovf12); else passed++;
    endtask

    initial begin
        test_reset();
        test_reset_midop();
        test_carry_chain();
        test_add_ovf();
        test_subtract();
        test_back_to_back();
        test_stream();
        test_corners();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
